// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage register file with a register-dump streamer.
//
// Holds 2**ADDR_W registers of DATA_W bits. Register 0 is hard-wired to zero.
// The writeback value is selected between the ALU result and the memory read
// data, then written on the rising clock edge when enabled. Two combinational
// read ports (rs, rt) serve the decode stage. A small IDLE/DUMP/DONE FSM
// streams every register out over a valid/ready port on request.
//
// Optional feature (macro WB_REGFILE_BYPASS_EN): read ports forward the
// in-flight writeback value when they address the register being written in
// the same cycle. The dump port never forwards; it always shows stored state.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   reg_write_en_i       writeback enable
//   mem_to_reg_i         1 = write mem_rdata_i, 0 = write alu_i
//   reg_write_addr_i     destination register
//   alu_i, mem_rdata_i   writeback data sources
//   rs_addr_i/rt_addr_i  read addresses; rs_data_o/rt_data_o read data
//   dump_req_i           one-cycle request to stream all registers
//   dump_ready_i         consumer ready
//   dump_valid_o         beat valid; dump_addr_o/dump_data_o beat payload
//   dump_done_o          one-cycle pulse after the final beat is accepted
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              reg_write_en_i,
  input  logic              mem_to_reg_i,
  input  logic [ADDR_W-1:0] reg_write_addr_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  input  logic              dump_req_i,
  input  logic              dump_ready_i,
  output logic              dump_valid_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_done_o
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_e;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [DATA_W-1:0] wb_data;
  logic              wr_act;

  // ---------------------------------------------------------------------------
  // Writeback
  // ---------------------------------------------------------------------------
  assign wb_data = mem_to_reg_i ? mem_rdata_i : alu_i;
  // Writes to r0 are dropped here, so r0 stays zero in storage as well.
  assign wr_act  = reg_write_en_i && (reg_write_addr_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_act) regs_d[reg_write_addr_i] = wb_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
    rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`ifdef WB_REGFILE_BYPASS_EN
    // Forward the value being written this cycle so a dependent read does
    // not have to wait for the edge. wr_act already excludes r0.
    if (wr_act && (rs_addr_i == reg_write_addr_i)) rs_data_o = wb_data;
    if (wr_act && (rt_addr_i == reg_write_addr_i)) rt_data_o = wb_data;
`endif
  end

  // ---------------------------------------------------------------------------
  // Dump FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_valid_o = 1'b0;
    dump_done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_req_i) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        dump_valid_o = 1'b1;
        if (dump_ready_i) begin
          // Index wraps to 0 after the last beat, leaving it clean for DONE.
          idx_d = idx_q + 1'b1;
          if (idx_q == {ADDR_W{1'b1}}) state_d = DONE;
        end
      end
      DONE: begin
        dump_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Dump payload is always the stored value; it tracks writes to the entry
  // while a beat is stalled, since it reads regs_q directly.
  assign dump_addr_o = idx_q;
  assign dump_data_o = regs_q[idx_q];

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- self-checking bench for wb_regfile.
// A behavioural model (array of register values plus a beat counter for the
// dump stream) is compared with the DUT on every falling edge; directed tests
// add hand-computed literal expectations.
module tb_wb_regfile;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0, m2r = 1'b0;
  logic [AW-1:0] waddr = '0, rs_a = '0, rt_a = '0;
  logic [DW-1:0] alu = '0, mrd = '0;
  logic [DW-1:0] rs_d, rt_d;
  logic          dreq = 1'b0, drdy = 1'b0;
  logic          dvld, ddone;
  logic [AW-1:0] daddr;
  logic [DW-1:0] ddata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .reg_write_en_i(we), .mem_to_reg_i(m2r), .reg_write_addr_i(waddr),
    .alu_i(alu), .mem_rdata_i(mrd),
    .rs_addr_i(rs_a), .rt_addr_i(rt_a), .rs_data_o(rs_d), .rt_data_o(rt_d),
    .dump_req_i(dreq), .dump_ready_i(drdy),
    .dump_valid_o(dvld), .dump_addr_o(daddr), .dump_data_o(ddata),
    .dump_done_o(ddone)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  bit            m_dumping;   // a dump stream is in progress
  int            m_beat;      // next beat number to be delivered
  bit            m_done;      // done pulse owed this cycle

  function automatic logic [DW-1:0] m_wb();
    return m2r ? mrd : alu;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
    if (we && waddr != 0 && a == waddr) return m_wb();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_dumping = 0; m_beat = 0; m_done = 0;
    end else begin
      if (m_done) m_done = 0;
      else if (m_dumping) begin
        if (drdy) begin
          m_beat++;
          if (m_beat == NR) begin m_dumping = 0; m_done = 1; end
        end
      end else if (dreq) begin
        m_dumping = 1; m_beat = 0;
      end
      if (we && waddr != 0) m_regs[waddr] = m_wb();
    end
  end

  always @(negedge clk) begin
    chk("rs_data", 32'(rs_d), 32'(m_read(rs_a)));
    chk("rt_data", 32'(rt_d), 32'(m_read(rt_a)));
    chk("dump_valid", 32'(dvld), 32'(m_dumping));
    chk("dump_done", 32'(ddone), 32'(m_done));
    if (m_dumping) begin
      chk("dump_addr", 32'(daddr), 32'(m_beat));
      chk("dump_data", 32'(ddata), 32'(m_regs[m_beat]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] av,
                    input logic [DW-1:0] mv, input logic sel);
    we = 1; waddr = a; alu = av; mrd = mv; m2r = sel;
    step();
    we = 0;
  endtask

  initial begin
    int k, beats, vcyc, dones;
    bit order_ok;

    #2;
    chk("reset_valid", 32'(dvld), 32'd0);
    chk("reset_done", 32'(ddone), 32'd0);
    #10 rst_n = 1;            // release mid-cycle
    rs_a = 4'd9;
    #1 chk("reset_rs", 32'(rs_d), 32'd0);
    step();

    // alu writeback, visible next cycle
    wr(4'd5, 16'h1234, 16'h0000, 1'b0);
    rs_a = 4'd5; #2 chk("r5_alu", 32'(rs_d), 32'h1234);

    // memory writeback selected
    wr(4'd3, 16'h0001, 16'hBEEF, 1'b1);
    rt_a = 4'd3; #2 chk("r3_mem", 32'(rt_d), 32'hBEEF);

    // r0 is immutable
    wr(4'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    rs_a = 4'd0; #2 chk("r0_zero", 32'(rs_d), 32'h0000);

    // same-cycle read of register being written
    wr(4'd7, 16'h0055, 16'h0000, 1'b0);
    we = 1; waddr = 4'd7; alu = 16'h00AA; m2r = 0; rt_a = 4'd7;
    #2;
`ifdef WB_REGFILE_BYPASS_EN
    chk("r7_same_cycle", 32'(rt_d), 32'h00AA);
`else
    chk("r7_same_cycle", 32'(rt_d), 32'h0055);
`endif
    step(); we = 0;
    #2 chk("r7_after", 32'(rt_d), 32'h00AA);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); waddr = 4'($urandom); alu = 16'($urandom);
      mrd = 16'($urandom); m2r = 1'($urandom);
      rs_a = 4'($urandom); rt_a = 4'($urandom);
      step();
    end
    we = 0;

    // known contents, then dump with ready toggling 0/1
    for (int i = 1; i < NR; i++) wr(4'(i), 16'(i * 16'h0111), 16'h0, 1'b0);
    drdy = 0; dreq = 1; step(); dreq = 0;
    k = 0; beats = 0; vcyc = 0; dones = 0; order_ok = 1;
    while (k < 40) begin
      drdy = k[0];
      if (k == 5) begin we = 1; waddr = 4'd10; alu = 16'hA5A5; m2r = 0; end
      if (k == 6) we = 0;
      dreq = (k == 8);        // ignored while dumping
      #2;
      if (dvld) vcyc++;
      if (dvld && drdy) begin
        if (32'(daddr) != beats) order_ok = 0;
        beats++;
      end
      if (ddone) dones++;
      step();
      k++;
    end
    dreq = 0; we = 0;
    chk("dump_beats", 32'(beats), 32'd16);
    chk("dump_cycles", 32'(vcyc), 32'd32);
    chk("dump_done_pulses", 32'(dones), 32'd1);
    chk("dump_order", 32'(order_ok), 32'd1);

    // reset in the middle of a dump at beat 6
    drdy = 1; dreq = 1; step(); dreq = 0;
    for (int i = 0; i < 6; i++) step();
    #2 chk("pre_reset_addr", 32'(daddr), 32'd6);
    rst_n = 0; rs_a = 4'd5; rt_a = 4'd3;
    #1;
    chk("abort_valid", 32'(dvld), 32'd0);
    chk("abort_rs", 32'(rs_d), 32'd0);
    chk("abort_rt", 32'(rt_d), 32'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin step(); if (ddone) dones++; end
    #3 rst_n = 1;
    drdy = 0;
    for (int i = 0; i < 4; i++) begin #2; if (ddone) dones++; step(); end
    chk("abort_no_done", 32'(dones), 32'd0);

    // first write after reset is honoured on the first edge
    rst_n = 0; #2 rst_n = 1;
    wr(4'd2, 16'h0077, 16'h0, 1'b0);
    rs_a = 4'd2; #2 chk("post_reset_wr", 32'(rs_d), 32'h0077);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
